// File: rtl/pc_fetch_if.sv
// pc_fetch_if: fetch-stage bus bundling next-PC, instruction-memory and decode handshakes.
interface pc_fetch_if;
  logic [31:0] npc_in;
  logic        npc_redirect;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic [31:0] inst_pcplus4;
  modport master (
    input  npc_in, npc_redirect, imem_ack, imem_rdata, inst_ready,
    output imem_req, imem_addr, inst_valid, inst_out, inst_pc, inst_pcplus4
  );
  modport slave (
    output npc_in, npc_redirect, imem_ack, imem_rdata, inst_ready,
    input  imem_req, imem_addr, inst_valid, inst_out, inst_pc, inst_pcplus4
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register, imem fetch with redirect/drop handling, 2-entry instruction buffer.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input logic         clk,
  input logic         rst,
  pc_fetch_if.master  bus
);
  typedef enum logic {RUN, DROP} state_t;
  state_t      state;
  logic [31:0] fetch_pc, drop_addr, data0, data1, pc0, pc1;
  logic [1:0]  count;
  logic        fire, push, pop;
  always_comb begin
    bus.imem_req     = !rst && (state == DROP || count < 2'(BUF_DEPTH));
    bus.imem_addr    = state == DROP ? drop_addr : fetch_pc;
    fire             = bus.imem_req && bus.imem_ack;
    push             = fire && state == RUN && !bus.npc_redirect;
    pop              = count != 2'd0 && bus.inst_ready && !bus.npc_redirect;
    bus.inst_valid   = count != 2'd0;
    bus.inst_out     = data0;
    bus.inst_pc      = pc0;
    bus.inst_pcplus4 = pc0 + 32'd4;
  end
  // entry 0 is the head; a pop shifts entry 1 down, a push lands behind the surviving entries
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      fetch_pc  <= RESET_PC;
      drop_addr <= '0;
      count     <= '0;
      data0     <= '0;
      data1     <= '0;
      pc0       <= '0;
      pc1       <= '0;
    end else if (bus.npc_redirect) begin
      fetch_pc <= {bus.npc_in[31:2], 2'b00};
      count    <= '0;
      if (state == RUN && bus.imem_req && !bus.imem_ack) begin
        drop_addr <= fetch_pc;
        state     <= DROP;
      end else if (state == DROP && bus.imem_ack) state <= RUN;
    end else begin
      if (state == DROP && bus.imem_ack) state <= RUN;
      if (push) fetch_pc <= fetch_pc + 32'd4;
      if (pop) begin
        data0 <= data1;
        pc0   <= pc1;
      end
      if (push && count[0] && !pop) begin
        data1 <= bus.imem_rdata;
        pc1   <= fetch_pc;
      end else if (push) begin
        data0 <= bus.imem_rdata;
        pc0   <= fetch_pc;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed scenario tasks for pc_fetch_unit; memory returns addr ^ KEY.
module tb_pc_fetch_unit;
  localparam logic [31:0] KEY = 32'hA5A5_0000;
  logic clk = 0;
  logic rst = 0;
  int   pass = 0;
  int   total = 0;
  pc_fetch_if bus ();
  pc_fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.imem_rdata = bus.imem_addr ^ KEY;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset(input logic ack, input logic rdy);
    @(posedge clk);
    #1;
    rst = 1;
    bus.imem_ack = ack;
    bus.inst_ready = rdy;
    bus.npc_redirect = 0;
    bus.npc_in = 0;
    step();
    rst = 0;
  endtask
  task automatic test_reset();
    rst = 1;
    bus.imem_ack = 1;
    bus.inst_ready = 1;
    bus.npc_redirect = 0;
    bus.npc_in = 0;
    #3;
    total++; if (bus.imem_req !== 1'b0) $display("FAIL rst_req got %b want 0", bus.imem_req); else pass++;
    total++; if (bus.inst_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", bus.inst_valid); else pass++;
    total++; if (bus.inst_out !== 32'h0) $display("FAIL rst_out got %h want 0", bus.inst_out); else pass++;
    total++; if (bus.inst_pc !== 32'h0) $display("FAIL rst_pc got %h want 0", bus.inst_pc); else pass++;
    total++; if (bus.inst_pcplus4 !== 32'h4) $display("FAIL rst_pcplus4 got %h want 4", bus.inst_pcplus4); else pass++;
    step();
    rst = 0;
    #1;
    total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) $display("FAIL first_req got %b/%h want 1/0", bus.imem_req, bus.imem_addr); else pass++;
  endtask
  task automatic test_stream();
    logic [31:0] exp_pc [3] = '{32'h0, 32'h4, 32'h8};
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== exp_pc[i]) $display("FAIL stream_pc%0d got %b/%h want 1/%h", i, bus.inst_valid, bus.inst_pc, exp_pc[i]); else pass++;
      total++; if (bus.inst_pcplus4 !== exp_pc[i] + 32'd4) $display("FAIL stream_pp4_%0d got %h want %h", i, bus.inst_pcplus4, exp_pc[i] + 32'd4); else pass++;
      total++; if (bus.inst_out !== (exp_pc[i] ^ KEY)) $display("FAIL stream_out%0d got %h want %h", i, bus.inst_out, exp_pc[i] ^ KEY); else pass++;
    end
  endtask
  task automatic test_backpressure();
    logic [31:0] exp_pc [3] = '{32'h0, 32'h4, 32'h8};
    do_reset(1, 0);
    step();
    total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4) $display("FAIL bp_second_req got %b/%h want 1/4", bus.imem_req, bus.imem_addr); else pass++;
    step();
    total++; if (bus.imem_req !== 1'b0) $display("FAIL bp_full_req got %b want 0", bus.imem_req); else pass++;
    step();
    total++; if (bus.imem_req !== 1'b0 || bus.inst_pc !== 32'h0) $display("FAIL bp_hold got %b/%h want 0/0", bus.imem_req, bus.inst_pc); else pass++;
    bus.inst_ready = 1;
    #1;
    total++; if (bus.imem_req !== 1'b0) $display("FAIL bp_no_bypass got %b want 0", bus.imem_req); else pass++;
    for (int i = 0; i < 3; i++) begin
      total++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== exp_pc[i] || bus.inst_out !== (exp_pc[i] ^ KEY)) $display("FAIL bp_order%0d got %b/%h/%h want 1/%h/%h", i, bus.inst_valid, bus.inst_pc, bus.inst_out, exp_pc[i], exp_pc[i] ^ KEY); else pass++;
      step();
    end
  endtask
  task automatic test_drop();
    do_reset(1, 1);
    step();
    step();
    bus.imem_ack = 0;
    step();
    total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8 || bus.inst_valid !== 1'b0) $display("FAIL drop_wait got %b/%h/%b want 1/8/0", bus.imem_req, bus.imem_addr, bus.inst_valid); else pass++;
    bus.npc_redirect = 1;
    bus.npc_in = 32'h100;
    step();
    bus.npc_redirect = 0;
    total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8) $display("FAIL drop_hold1 got %b/%h want 1/8", bus.imem_req, bus.imem_addr); else pass++;
    step();
    total++; if (bus.imem_addr !== 32'h8 || bus.inst_valid !== 1'b0) $display("FAIL drop_hold2 got %h/%b want 8/0", bus.imem_addr, bus.inst_valid); else pass++;
    bus.imem_ack = 1;
    step();
    total++; if (bus.imem_addr !== 32'h100 || bus.inst_valid !== 1'b0) $display("FAIL drop_next got %h/%b want 100/0", bus.imem_addr, bus.inst_valid); else pass++;
    step();
    total++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h100 || bus.inst_out !== (32'h100 ^ KEY)) $display("FAIL drop_target got %b/%h/%h want 1/100/%h", bus.inst_valid, bus.inst_pc, bus.inst_out, 32'h100 ^ KEY); else pass++;
  endtask
  task automatic test_double_redirect();
    do_reset(0, 1);
    bus.npc_redirect = 1;
    bus.npc_in = 32'h100;
    step();
    bus.npc_in = 32'h200;
    step();
    bus.npc_redirect = 0;
    total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) $display("FAIL dbl_hold got %b/%h want 1/0", bus.imem_req, bus.imem_addr); else pass++;
    bus.imem_ack = 1;
    step();
    total++; if (bus.imem_addr !== 32'h200 || bus.inst_valid !== 1'b0) $display("FAIL dbl_next got %h/%b want 200/0", bus.imem_addr, bus.inst_valid); else pass++;
    step();
    total++; if (bus.inst_pc !== 32'h200) $display("FAIL dbl_pc got %h want 200", bus.inst_pc); else pass++;
  endtask
  task automatic test_align();
    do_reset(1, 1);
    step();
    bus.npc_redirect = 1;
    bus.npc_in = 32'h0000_0123;
    step();
    bus.npc_redirect = 0;
    total++; if (bus.inst_valid !== 1'b0 || bus.imem_addr !== 32'h120) $display("FAIL align got %b/%h want 0/120", bus.inst_valid, bus.imem_addr); else pass++;
    step();
    total++; if (bus.inst_pc !== 32'h120 || bus.inst_out !== (32'h120 ^ KEY)) $display("FAIL align_pc got %h/%h want 120/%h", bus.inst_pc, bus.inst_out, 32'h120 ^ KEY); else pass++;
  endtask
  task automatic test_wrap_and_reset();
    bus.npc_redirect = 1;
    bus.npc_in = 32'hFFFF_FFFC;
    step();
    bus.npc_redirect = 0;
    total++; if (bus.imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_addr got %h want fffffffc", bus.imem_addr); else pass++;
    step();
    total++; if (bus.imem_addr !== 32'h0 || bus.inst_pc !== 32'hFFFF_FFFC || bus.inst_pcplus4 !== 32'h0) $display("FAIL wrap got %h/%h/%h want 0/fffffffc/0", bus.imem_addr, bus.inst_pc, bus.inst_pcplus4); else pass++;
    step();
    total++; if (bus.imem_req !== 1'b1 || bus.inst_valid !== 1'b1) $display("FAIL pre_rst got %b/%b want 1/1", bus.imem_req, bus.inst_valid); else pass++;
    #2;
    rst = 1;
    #1;
    total++; if (bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b0 || bus.inst_pc !== 32'h0) $display("FAIL async_rst got %b/%b/%h want 0/0/0", bus.imem_req, bus.inst_valid, bus.inst_pc); else pass++;
    step();
    rst = 0;
    #1;
    total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) $display("FAIL post_rst got %b/%h want 1/0", bus.imem_req, bus.imem_addr); else pass++;
  endtask
  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_drop();
    test_double_redirect();
    test_align();
    test_wrap_and_reset();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
